contador_mod_updown: RTL and testbench

CONTADOR_MOD_UPDOWN -- requirements
Module: contador_mod_updown

---
 rtl/contador_mod_updown_pkg.sv | 10 +
 rtl/contador_mod_updown.sv | 99 +++++++++
 tb/tb_contador_mod_updown.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/contador_mod_updown_pkg.sv
// rtl/contador_mod_updown_pkg.sv - shared direction and saturation-mode constants
package contador_mod_updown_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int SAT_WRAP = 0;
  localparam int SAT_HOLD = 1;

endpackage

// File: rtl/contador_mod_updown.sv
// rtl/contador_mod_updown.sv - modulo-N up/down counter with clear, load, cascade carry and wrap/load-error pulses
module contador_mod_updown
  import contador_mod_updown_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 6,
  parameter int SATURATE = SAT_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             ld,
  input  logic             ent,
  input  logic             enp,
  input  logic             up,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             wrap,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $fatal(1, "contador_mod_updown: MODULUS=%0d outside 2..2**WIDTH (WIDTH=%0d)", MODULUS, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_Q = '0;
  localparam logic             HOLD   = (SATURATE == SAT_HOLD);

  // Initialisers give a defined count at time zero, before the first reset edge.
  logic [WIDTH-1:0] q_q        = '0;
  logic             wrap_q     = 1'b0;
  logic             load_err_q = 1'b0;

  logic [WIDTH-1:0] q_d;
  logic             wrap_d;
  logic             load_err_d;
  logic             at_tc;

  always_comb begin
    at_tc = (up == DIR_UP) ? (q_q == MAX_Q) : (q_q == ZERO_Q);
    rco   = ent & at_tc;
  end

  always_comb begin
    q_d        = q_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (!clr) begin
      q_d = '0;
    end else if (!ld) begin
      // Out-of-range loads clamp to the top of the range and flag the error.
      if (D > MAX_Q) begin
        q_d        = MAX_Q;
        load_err_d = 1'b1;
      end else begin
        q_d = D;
      end
    end else if (ent && enp) begin
      if (up == DIR_UP) begin
        if (q_q == MAX_Q) begin
          if (!HOLD) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (q_q == ZERO_Q) begin
          if (!HOLD) begin
            q_d    = MAX_Q;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign Q        = q_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_contador_mod_updown.sv
// tb/tb_contador_mod_updown.sv - directed self-checking bench, wrapping and saturating instances side by side
module tb_contador_mod_updown;

  logic       clock = 1'b0;
  logic       reset, clr, ld, ent, enp, up;
  logic [3:0] d;
  logic [3:0] q_w, q_s;
  logic       rco_w, rco_s, wrap_w, wrap_s, lerr_w, lerr_s;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  contador_mod_updown #(.WIDTH(4), .MODULUS(6), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .clr(clr), .ld(ld), .ent(ent), .enp(enp), .up(up),
    .D(d), .Q(q_w), .rco(rco_w), .wrap(wrap_w), .load_err(lerr_w)
  );

  contador_mod_updown #(.WIDTH(4), .MODULUS(6), .SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .clr(clr), .ld(ld), .ent(ent), .enp(enp), .up(up),
    .D(d), .Q(q_s), .rco(rco_s), .wrap(wrap_s), .load_err(lerr_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int seq_up_w[7]  = '{0, 1, 2, 3, 4, 5, 0};
  int seq_dn_w[5]  = '{2, 1, 0, 5, 4};
  int seq_dn_s[5]  = '{2, 1, 0, 0, 0};
  int seq_sat_s[5] = '{3, 4, 5, 5, 5};
  int seq_sat_w[5] = '{3, 4, 5, 0, 1};

  initial begin
    reset = 1'b1; clr = 1'b1; ld = 1'b1; ent = 1'b0; enp = 1'b0; up = 1'b1; d = 4'd0;
    #1;
    chk("q_time_zero", 32'(q_w), 0);

    step();
    chk("reset_q", 32'(q_w), 0);
    chk("reset_wrap", 32'(wrap_w), 0);
    chk("reset_load_err", 32'(lerr_w), 0);

    // Count up through the terminal value and wrap.
    reset = 1'b0; ent = 1'b1; enp = 1'b1; up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("up_q[%0d]", i), 32'(q_w), 32'(seq_up_w[i]));
      chk($sformatf("up_rco[%0d]", i), 32'(rco_w), 32'(seq_up_w[i] == 5));
      chk($sformatf("up_wrap[%0d]", i), 32'(wrap_w), 32'(i == 6));
      if (i < 6) step();
    end
    chk("sat_up_hold_q", 32'(q_s), 5);
    chk("sat_up_wrap", 32'(wrap_s), 0);

    // Count down from 2 through zero.
    ld = 1'b0; d = 4'd2;
    step();
    chk("load2_wrap_cleared", 32'(wrap_w), 0);
    ld = 1'b1; up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("dn_q[%0d]", i), 32'(q_w), 32'(seq_dn_w[i]));
      chk($sformatf("dn_rco[%0d]", i), 32'(rco_w), 32'(seq_dn_w[i] == 0));
      chk($sformatf("dn_wrap[%0d]", i), 32'(wrap_w), 32'(i == 3));
      chk($sformatf("sat_dn_q[%0d]", i), 32'(q_s), 32'(seq_dn_s[i]));
      chk($sformatf("sat_dn_wrap[%0d]", i), 32'(wrap_s), 0);
      if (i < 4) step();
    end

    // Saturating count up from 3.
    ld = 1'b0; d = 4'd3;
    step();
    ld = 1'b1; up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("sat_q[%0d]", i), 32'(q_s), 32'(seq_sat_s[i]));
      chk($sformatf("sat_rco[%0d]", i), 32'(rco_s), 32'(seq_sat_s[i] == 5));
      chk($sformatf("sat_wrap[%0d]", i), 32'(wrap_s), 0);
      chk($sformatf("satcmp_w_q[%0d]", i), 32'(q_w), 32'(seq_sat_w[i]));
      chk($sformatf("satcmp_w_wrap[%0d]", i), 32'(wrap_w), 32'(i == 3));
      if (i < 4) step();
    end

    // Loads: out of range, in range, boundary values.
    ent = 1'b0; enp = 1'b0;
    ld = 1'b0; d = 4'd9;
    step();
    chk("ld9_q", 32'(q_w), 5);
    chk("ld9_load_err", 32'(lerr_w), 1);
    chk("ld9_sat_load_err", 32'(lerr_s), 1);
    d = 4'd2;
    step();
    chk("ld2_q", 32'(q_w), 2);
    chk("ld2_load_err", 32'(lerr_w), 0);
    d = 4'd5;
    step();
    chk("ld5_q", 32'(q_w), 5);
    chk("ld5_load_err", 32'(lerr_w), 0);
    d = 4'd6;
    step();
    chk("ld6_q", 32'(q_w), 5);
    chk("ld6_load_err", 32'(lerr_w), 1);
    ld = 1'b1;
    step();
    chk("ld6_pulse_ends", 32'(lerr_w), 0);

    // Clear beats load on the same edge.
    ld = 1'b0; d = 4'd4;
    step();
    chk("ld4_q", 32'(q_w), 4);
    clr = 1'b0; ld = 1'b0; d = 4'd1; ent = 1'b1; enp = 1'b1;
    step();
    chk("clr_over_ld_q", 32'(q_w), 0);
    chk("clr_over_ld_sat_q", 32'(q_s), 0);

    // Reset on the edge that would wrap cancels the pulse.
    clr = 1'b1; ld = 1'b0; d = 4'd5; ent = 1'b0; enp = 1'b0;
    step();
    ld = 1'b1; ent = 1'b1; enp = 1'b1; up = 1'b1; reset = 1'b1;
    step();
    chk("rst_wrap_pending_q", 32'(q_w), 0);
    chk("rst_wrap_pending_wrap", 32'(wrap_w), 0);

    // Reset cancels a load error pulse.
    reset = 1'b0; ent = 1'b0; enp = 1'b0; ld = 1'b0; d = 4'd9;
    step();
    chk("pre_rst_load_err", 32'(lerr_w), 1);
    reset = 1'b1;
    step();
    chk("rst_load_err", 32'(lerr_w), 0);
    chk("rst_load_err_q", 32'(q_w), 0);

    // Parallel enable low: hold with rco tracking ent/up.
    reset = 1'b0; ld = 1'b0; d = 4'd5;
    step();
    ld = 1'b1; ent = 1'b1; enp = 1'b0; up = 1'b1;
    #1;
    chk("hold_rco_ent1", 32'(rco_w), 1);
    step();
    chk("hold_q", 32'(q_w), 5);
    chk("hold_rco_after_edge", 32'(rco_w), 1);
    ent = 1'b0;
    #1;
    chk("hold_rco_ent0", 32'(rco_w), 0);
    step();
    chk("hold_q_ent0", 32'(q_w), 5);
    ent = 1'b1; up = 1'b0;
    #1;
    chk("dirflip_rco", 32'(rco_w), 0);
    step();
    chk("dirflip_q", 32'(q_w), 5);

    // Clear does not gate rco; it only acts at the edge.
    up = 1'b1; clr = 1'b0;
    #1;
    chk("clr_rco", 32'(rco_w), 1);
    step();
    chk("clr_q", 32'(q_w), 0);
    chk("clr_wrap", 32'(wrap_w), 0);
    clr = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
